dmux4way16_router: RTL and testbench

//   Registered 1-to-4 demultiplexer for 16-bit words: the receive-side counterpart of the 4-way
//   16-bit mux. Accepts one word per cycle on a valid/ready input port, steered by a 2-bit select.

---
 rtl/dmux4way16_router_if.sv | 29 ++
 rtl/dmux4way16_router.sv | 56 +++++
 tb/tb_dmux4way16_router.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmux4way16_router_if.sv
// Bus bundle for the 1-to-4 word router: select-steered input port, four drained output channels.
// master = upstream source + downstream sinks; slave = the router itself.
interface dmux4way16_router_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic             busy;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_valid, busy, xfer_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_valid, busy, xfer_count
  );
endinterface

// File: rtl/dmux4way16_router.sv
// Registered 1-to-4 word demux with a one-entry holding register per channel; 1-cycle latency.
// in_ready stalls only on the selected channel, and a full channel may drain and reload on the same edge.
module dmux4way16_router #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  dmux4way16_router_if.slave  bus
);

  logic [WIDTH-1:0] r_buf [4];
  logic [3:0]       r_vld;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_acc;
  logic [3:0]       w_acc_oh;

  assign w_in_ready = ~r_vld[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_acc_oh   = {4{w_acc}} & (4'b0001 << bus.in_sel);

  // A reload on the accepting channel takes priority over its drain so v_k stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        r_buf[k] <= '0;
      end
      r_vld <= '0;
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_acc_oh[k]) begin
          r_buf[k] <= bus.in_data;
          r_vld[k] <= 1'b1;
        end else if (bus.out_ready[k]) begin
          r_vld[k] <= 1'b0;
        end
      end
      if (w_acc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_a      = r_buf[0];
  assign bus.out_b      = r_buf[1];
  assign bus.out_c      = r_buf[2];
  assign bus.out_d      = r_buf[3];
  assign bus.out_valid  = r_vld;
  assign bus.busy       = |r_vld;
  assign bus.xfer_count = r_cnt;

endmodule

// File: tb/tb_dmux4way16_router.sv
// Directed, table-driven bench for dmux4way16_router plus hand sequences for async reset and counter wrap.
module tb_dmux4way16_router;

  logic clk;
  logic reset;

  dmux4way16_router_if #(.WIDTH(16), .CNT_W(8)) bus ();

  dmux4way16_router #(.WIDTH(16), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        vld;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] exp_c;
    logic [15:0] exp_d;
    logic [7:0]  exp_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] dat, input logic [1:0] sel, input logic vld,
                              input logic [3:0] ordy, input logic rdy, input logic [3:0] ov,
                              input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [7:0] cnt);
    vec_t v;
    v.dat = dat; v.sel = sel; v.vld = vld; v.ordy = ordy; v.exp_rdy = rdy; v.exp_ov = ov;
    v.exp_a = a; v.exp_b = b; v.exp_c = c; v.exp_d = d; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic drive(input logic [15:0] dat, input logic [1:0] sel, input logic vld, input logic [3:0] ordy);
    bus.in_data   = dat;
    bus.in_sel    = sel;
    bus.in_valid  = vld;
    bus.out_ready = ordy;
  endtask

  initial begin
    // in-order sweep, all sinks ready
    tv[0]  = mk(16'h1234, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0001, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 8'd1);
    tv[1]  = mk(16'h9876, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0010, 16'h1234, 16'h9876, 16'h0000, 16'h0000, 8'd2);
    tv[2]  = mk(16'hAAAA, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 16'h1234, 16'h9876, 16'hAAAA, 16'h0000, 8'd3);
    tv[3]  = mk(16'h5555, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000, 16'h1234, 16'h9876, 16'hAAAA, 16'h5555, 8'd4);
    tv[4]  = mk(16'h0000, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h1234, 16'h9876, 16'hAAAA, 16'h5555, 8'd4);
    // channel c stalled, then drain + reload on one edge
    tv[5]  = mk(16'hAAAA, 2'd2, 1'b1, 4'b1011, 1'b1, 4'b0100, 16'h1234, 16'h9876, 16'hAAAA, 16'h5555, 8'd5);
    tv[6]  = mk(16'h0F0F, 2'd2, 1'b1, 4'b1011, 1'b0, 4'b0100, 16'h1234, 16'h9876, 16'hAAAA, 16'h5555, 8'd5);
    tv[7]  = mk(16'h0F0F, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 16'h1234, 16'h9876, 16'h0F0F, 16'h5555, 8'd6);
    tv[8]  = mk(16'h0000, 2'd2, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h1234, 16'h9876, 16'h0F0F, 16'h5555, 8'd6);
    // a and d fill, a stalls, then both drain while b accepts
    tv[9]  = mk(16'h1111, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h1111, 16'h9876, 16'h0F0F, 16'h5555, 8'd7);
    tv[10] = mk(16'h4444, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1001, 16'h1111, 16'h9876, 16'h0F0F, 16'h4444, 8'd8);
    tv[11] = mk(16'h2222, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b1001, 16'h1111, 16'h9876, 16'h0F0F, 16'h4444, 8'd8);
    tv[12] = mk(16'hBEEF, 2'd1, 1'b1, 4'b1001, 1'b1, 4'b0010, 16'h1111, 16'hBEEF, 16'h0F0F, 16'h4444, 8'd9);
    tv[13] = mk(16'h0000, 2'd1, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h1111, 16'hBEEF, 16'h0F0F, 16'h4444, 8'd9);
    // all-zero words are real transfers; sinks held off so all four fill
    tv[14] = mk(16'h0000, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h0000, 16'hBEEF, 16'h0F0F, 16'h4444, 8'd10);
    tv[15] = mk(16'h0000, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 16'h0000, 16'h0000, 16'h0F0F, 16'h4444, 8'd11);
    tv[16] = mk(16'h0000, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h0000, 16'h0000, 16'h0000, 16'h4444, 8'd12);
    tv[17] = mk(16'h0000, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd13);
    tv[18] = mk(16'h7777, 2'd2, 1'b1, 4'b0000, 1'b0, 4'b1111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd13);

    reset = 1'b1;
    drive(16'h0000, 2'd0, 1'b0, 4'b1111);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(bus.xfer_count), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].dat, tv[i].sel, tv[i].vld, tv[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tv[i].exp_ov));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(|tv[i].exp_ov));
      chk($sformatf("v%0d_out_a", i), 32'(bus.out_a), 32'(tv[i].exp_a));
      chk($sformatf("v%0d_out_b", i), 32'(bus.out_b), 32'(tv[i].exp_b));
      chk($sformatf("v%0d_out_c", i), 32'(bus.out_c), 32'(tv[i].exp_c));
      chk($sformatf("v%0d_out_d", i), 32'(bus.out_d), 32'(tv[i].exp_d));
      chk($sformatf("v%0d_count", i), 32'(bus.xfer_count), 32'(tv[i].exp_cnt));
    end

    // async reset pulse between edges with all four channels full
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_out_a", 32'(bus.out_a), 32'h0);
    chk("arst_out_b", 32'(bus.out_b), 32'h0);
    chk("arst_out_c", 32'(bus.out_c), 32'h0);
    chk("arst_out_d", 32'(bus.out_d), 32'h0);
    chk("arst_count", 32'(bus.xfer_count), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
    #1 reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("arst_release_in_ready", 32'(bus.in_ready), 32'h1);

    // counter wrap: 255 accepts then one more
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive(16'(i), 2'(i), 1'b1, 4'b1111);
      @(posedge clk);
      #1;
      if (i == 254) chk("wrap_count_255", 32'(bus.xfer_count), 32'd255);
    end
    chk("wrap_count_0", 32'(bus.xfer_count), 32'd0);
    chk("wrap_out_valid", 32'(bus.out_valid), 32'b1000);
    chk("wrap_out_d", 32'(bus.out_d), 32'h00FF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_idle_count", 32'(bus.xfer_count), 32'd0);
    chk("wrap_idle_valid", 32'(bus.out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
